// File: rtl/delay_line_ctrl.sv
// Programmable delay line with a priming state machine.
// A fixed chain of MAX_TAPS stages shifts every cycle; the output tap is
// selected by taps_active. After every (re)start the FSM waits taps_active
// cycles in PRIME so that only words that have travelled the full selected
// delay are ever flagged valid.
module delay_line_ctrl #(
  parameter int              WIDTH      = 40,
  parameter int              MAX_TAPS   = 16,
  parameter int              DEF_TAPS   = 10,
  parameter logic [WIDTH-1:0] BLANK_WORD = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_i,
  input  logic             cfg_valid,
  input  logic [6:0]       cfg_taps,
  output logic             cfg_ready,
  output logic [WIDTH-1:0] data_o,
  output logic             out_valid,
  output logic [6:0]       taps_active,
  output logic             busy
);

  localparam int         IW        = $clog2(MAX_TAPS);
  localparam logic [6:0] MAX_TAPS7 = 7'(MAX_TAPS);
  localparam logic [6:0] DEF_TAPS7 = 7'(DEF_TAPS);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t           state_reg, state_next;
  logic [6:0]       cnt_reg, cnt_next;
  logic [6:0]       taps_reg, taps_next;
  logic [6:0]       cfg_clamped;
  logic             accept;
  logic [IW-1:0]    tap_idx;
  logic [WIDTH-1:0] stage [MAX_TAPS];

  // Delay chain: shifts unconditionally; never flushed on reconfiguration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_TAPS; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data_i;
      for (int i = 1; i < MAX_TAPS; i++) stage[i] <= stage[i-1];
    end
  end

  // Clamp the requested delay into the legal range 1..MAX_TAPS.
  always_comb begin
    cfg_clamped = cfg_taps;
    if (cfg_taps == 7'd0)          cfg_clamped = 7'd1;
    else if (cfg_taps > MAX_TAPS7) cfg_clamped = MAX_TAPS7;
  end

  assign accept  = cfg_valid & cfg_ready;
  // Word sampled taps cycles ago sits in stage[taps-1] just before the edge.
  assign tap_idx = IW'(taps_reg - 7'd1);

  // State register with prime counter and active tap count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 7'd0;
      taps_reg  <= DEF_TAPS7;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      taps_reg  <= taps_next;
    end
  end

  // Next-state logic; a low enable overrides every other event.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    taps_next  = accept ? cfg_clamped : taps_reg;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = PRIME;
          cnt_next   = taps_next;
        end
      end
      PRIME: begin
        if (!enable)               state_next = IDLE;
        else if (cnt_reg == 7'd1)  state_next = RUN;
        else                       cnt_next   = cnt_reg - 7'd1;
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (accept) begin
          state_next = PRIME;
          cnt_next   = taps_next;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    busy      = (state_reg == PRIME);
    cfg_ready = (state_reg != PRIME);
  end

  assign taps_active = taps_reg;

  // Registered data path: valid and data follow the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      data_o    <= BLANK_WORD;
    end else if (state_next == RUN) begin
      out_valid <= 1'b1;
      data_o    <= stage[tap_idx];
    end else begin
      out_valid <= 1'b0;
      data_o    <= BLANK_WORD;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl: a table of per-edge vectors plus
// hand-written sequences for asynchronous reset behaviour.
module tb_delay_line_ctrl;

  localparam int WIDTH = 40;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic [WIDTH-1:0] data_i;
  logic             cfg_valid;
  logic [6:0]       cfg_taps;
  logic             cfg_ready;
  logic [WIDTH-1:0] data_o;
  logic             out_valid;
  logic [6:0]       taps_active;
  logic             busy;

  delay_line_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .data_i      (data_i),
    .cfg_valid   (cfg_valid),
    .cfg_taps    (cfg_taps),
    .cfg_ready   (cfg_ready),
    .data_o      (data_o),
    .out_valid   (out_valid),
    .taps_active (taps_active),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       cv;
    logic [6:0] ct;
    logic       ov;
    logic       bsy;
    logic [6:0] taps;
    int         lag;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ecnt  = 0;

  function automatic void add(int n, logic en, logic cv, logic [6:0] ct,
                              logic ov, logic bsy, logic [6:0] taps, int lag);
    vec_t v;
    v.en = en; v.cv = cv; v.ct = ct; v.ov = ov; v.bsy = bsy; v.taps = taps; v.lag = lag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; word sampled at edge n carries value n.
  task automatic step();
    @(posedge clk);
    ecnt++;
    #1;
    data_i = WIDTH'(ecnt + 1);
  endtask

  task automatic chk_all(string tag, logic ov, logic bsy, logic [6:0] taps, int lag);
    logic [WIDTH-1:0] exp_data;
    exp_data = ov ? WIDTH'(ecnt - lag) : '0;
    chk({tag, ".out_valid"},   64'(out_valid),   64'(ov));
    chk({tag, ".busy"},        64'(busy),        64'(bsy));
    chk({tag, ".cfg_ready"},   64'(cfg_ready),   64'(!bsy));
    chk({tag, ".taps_active"}, 64'(taps_active), 64'(taps));
    chk({tag, ".data_o"},      64'(data_o),      64'(exp_data));
    $display("%s en=%0b cv=%0b ct=%0d -> ov=%0b busy=%0b taps=%0d data=%0d",
             tag, enable, cfg_valid, cfg_taps, out_valid, busy, taps_active, data_o);
  endtask

  initial begin
    int n;
    reset_n = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_taps = '0; data_i = '0;

    // Table: starts in IDLE with default delay 10.
    add(1,  0,0,7'd0,   0,0,7'd10,0);
    add(10, 1,0,7'd0,   0,1,7'd10,0);
    add(3,  1,0,7'd0,   1,0,7'd10,10);
    add(1,  1,1,7'd3,   0,1,7'd3,0);
    add(1,  1,1,7'd50,  0,1,7'd3,0);   // ignored while priming
    add(1,  1,0,7'd0,   0,1,7'd3,0);
    add(3,  1,0,7'd0,   1,0,7'd3,3);
    add(1,  1,1,7'd0,   0,1,7'd1,0);   // clamp to 1
    add(2,  1,0,7'd0,   1,0,7'd1,1);
    add(1,  1,1,7'd100, 0,1,7'd16,0);  // clamp to 16
    add(15, 1,0,7'd0,   0,1,7'd16,0);
    add(2,  1,0,7'd0,   1,0,7'd16,16);
    for (int r = 0; r < 2; r++) begin  // second pass: same taps still reprimes
      add(1, 1,1,7'd2, 0,1,7'd2,0);
      add(1, 1,0,7'd0, 0,1,7'd2,0);
      add(1, 1,0,7'd0, 1,0,7'd2,2);
    end
    for (int r = 0; r < 3; r++) begin  // cfg_valid held high: one accept per RUN
      add(1, 1,1,7'd2, 0,1,7'd2,0);
      add(1, 1,1,7'd2, 0,1,7'd2,0);
      add(1, 1,1,7'd2, 1,0,7'd2,2);
    end
    add(1,  1,1,7'd5,   0,1,7'd5,0);
    add(1,  0,1,7'd9,   0,0,7'd5,0);   // enable drop mid-PRIME
    add(1,  0,1,7'd7,   0,0,7'd7,0);   // config in IDLE only stores
    add(7,  1,0,7'd0,   0,1,7'd7,0);
    add(1,  1,0,7'd0,   1,0,7'd7,7);
    add(1,  0,1,7'd4,   0,0,7'd4,0);   // config with enable drop in RUN
    add(1,  0,0,7'd0,   0,0,7'd4,0);

    // Reset state.
    #2 reset_n = 1'b0;
    #1 chk_all("reset", 1'b0, 1'b0, 7'd10, 0);
    step();
    step();
    #3 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; cfg_valid = vecs[i].cv; cfg_taps = vecs[i].ct;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].bsy, vecs[i].taps, vecs[i].lag);
    end

    // Restart with stored delay 4, bounded wait for valid output.
    enable = 1'b1; cfg_valid = 1'b0;
    n = 0;
    while (n < 20 && !out_valid) begin
      step();
      n++;
    end
    chk("prime_len4", 64'(n), 64'd5);
    chk_all("run4", 1'b1, 1'b0, 7'd4, 4);

    // Asynchronous reset between edges during RUN, with a config pending.
    #3 reset_n = 1'b0; cfg_valid = 1'b1; cfg_taps = 7'd3;
    #1 chk_all("async_rst", 1'b0, 1'b0, 7'd10, 0);
    step();
    chk_all("rst_held", 1'b0, 1'b0, 7'd10, 0);
    #3 reset_n = 1'b1; cfg_valid = 1'b0; enable = 1'b0;
    step();
    chk_all("post_rst_idle", 1'b0, 1'b0, 7'd10, 0);
    enable = 1'b1;
    step();
    chk_all("post_rst_prime", 1'b0, 1'b1, 7'd10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
